ppl_datamem_sized: RTL and testbench
====================================

Name: ppl_datamem_sized

Overview:
- Next-generation data memory for the pipelined CPU's MEM stage.
- Generalises the fixed 32-word data RAM in depth and in word-address base.
- Adds byte, halfword and word stores through byte lanes, sign/zero-extended sub-word loads, and a registered read port.
- Adds misalignment detection and a post-reset clear sweep that holds the pipeline off until the RAM is zeroed.

Parameters:
- ADDR_BITS, 5: word-address width; depth = 2**ADDR_BITS words of 32 bits.
- BASE_LSB, 2: lowest byte-address bit used as the word index. Word index = addr[BASE_LSB+ADDR_BITS-1:BASE_LSB].
- CLEAR_ON_RESET, 1: 1 = run the zeroing sweep after reset; 0 = go straight to READY.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  byte address from the EX/MEM register.
- dataIn  in  32  store data, right-justified.
- mWriteMem  in  1  store request.
- mReadMem  in  1  load request.
- mSize  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- mSigned  in  1  1 = sign-extend sub-word loads; 0 = zero-extend.
- dataOut  out  32  load data, registered, valid one cycle after the request.
- misaligned  out  1  registered fault flag for the request of the previous cycle.
- ready  out  1  high when the memory accepts requests.

Behaviour:
- Reset (asynchronous): state = CLEAR if CLEAR_ON_RESET, else READY; dataOut = 0; misaligned = 0; ready = 0 in CLEAR, 1 in READY; clear counter = 0.
  - Reset mid-sweep restarts the sweep at word 0.
  - RAM contents are not reset asynchronously.
- FSM CLEAR:
  - Writes word 0 at counter index each cycle; counter increments each cycle.
  - When counter = 2**ADDR_BITS-1 has been written, moves to READY on the next edge.
  - Sweep takes exactly 2**ADDR_BITS cycles.
  - Requests are ignored; dataOut holds 0; misaligned stays 0.
- FSM READY:
  - Terminal state until reset.
  - ready = 1, driven combinationally from state.
- Alignment: misaligned when half with addr[0] = 1, or word/reserved with addr[1:0] != 0.
  - A misaligned store writes nothing.
  - A misaligned load leaves dataOut unchanged.
  - misaligned is registered one cycle after a request that has mWriteMem or mReadMem high in READY; otherwise it is 0 next cycle.
- Byte lanes:
  - Byte store: writes lane addr[1:0] with dataIn[7:0].
  - Half store: writes lanes {addr[1],0} and {addr[1],1} with dataIn[15:0], low byte in the lower lane.
  - Word store: writes all four lanes with dataIn.
  - Unselected lanes keep their old contents.
- Load:
  - dataOut latches the selected byte/half/word on the edge after the request; latency is 1 cycle.
  - Byte and half loads shift the selected lane(s) to bit 0, then sign- or zero-extend per mSigned.
  - With mReadMem low, dataOut holds its last value.
- Write-first: a load and store to the same word in the same cycle returns the merged new word in dataOut.
  - Both mReadMem and mWriteMem high is legal.
- Address bits above BASE_LSB+ADDR_BITS-1 are ignored, so addresses alias and wrap modulo the depth.

Test Plan:
- Sweep: preload RAM with nonzero data, assert reset for 2 cycles, release.
  - Required: ready = 0 for exactly 32 cycles, then 1; a load from every word returns 0x00000000.
- Store/load word: sw 0x12345678 to 0x10, then lw 0x10.
  - Required: dataOut = 0x12345678 one cycle after the load; misaligned = 0.
- Sub-word store merge and extension: sw 0xAABBCCDD to 0x20, then sb 0x80 to 0x21.
  - Required: lw 0x20 returns 0xAABB80DD; lb 0x21 returns 0xFFFFFF80; lbu 0x21 returns 0x00000080.
  - Required: lh 0x22 returns 0xFFFFAABB; lhu 0x22 returns 0x0000AABB.
- Misalignment: sw 0x11111111 to 0x40, then sh 0xBEEF to 0x41, then lw 0x42.
  - Required: misaligned = 1 after each of the two bad requests; lw 0x40 still returns 0x11111111; dataOut unchanged by the misaligned lw.
- Read-during-write and wrap: same-cycle sw 0xCAFEF00D with lw, both to 0x0C.
  - Required: dataOut = 0xCAFEF00D next cycle.
  - Required: lw 0x8C with ADDR_BITS = 5 returns the same value (alias wrap).
- Reset mid-sweep: assert reset at sweep cycle 10.
  - Required: dataOut = 0, ready = 0 immediately; after release, the sweep runs a full 32 cycles.

Source files
------------

// File: rtl/ppl_datamem_sized_if.sv
// MEM-stage data memory bus: request from the pipeline, load data/status back.
interface ppl_datamem_sized_if;
  logic [31:0] addr;
  logic [31:0] dataIn;
  logic        mWriteMem;
  logic        mReadMem;
  logic [1:0]  mSize;
  logic        mSigned;
  logic [31:0] dataOut;
  logic        misaligned;
  logic        ready;

  modport master (
    output addr, dataIn, mWriteMem, mReadMem, mSize, mSigned,
    input  dataOut, misaligned, ready
  );

  modport slave (
    input  addr, dataIn, mWriteMem, mReadMem, mSize, mSigned,
    output dataOut, misaligned, ready
  );
endinterface

// File: rtl/ppl_datamem_sized.sv
// Sized data memory: byte-lane stores, extended sub-word loads, registered
// read port, misalignment flag and a post-reset zeroing sweep.
module ppl_datamem_sized #(
  parameter int ADDR_BITS      = 5,
  parameter int BASE_LSB       = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  ppl_datamem_sized_if.slave   bus
);
  localparam int DEPTH     = 2 ** ADDR_BITS;
  localparam int NUM_LANES = 4;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  clr_cnt_q, clr_cnt_d;
  logic [31:0]           data_out_q, data_out_d;
  logic                  misaligned_q, misaligned_d;

  logic [NUM_LANES-1:0][7:0] mem [DEPTH];

  logic [ADDR_BITS-1:0]      idx;
  logic [1:0]                bsel;
  logic                      mis;
  logic                      req_ok;
  logic                      wr_ok;
  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] wbyte;
  logic [NUM_LANES-1:0][7:0] rd_word;
  logic [NUM_LANES-1:0][7:0] merged;
  logic [31:0]               ld_data;

  logic                      ram_we;
  logic [ADDR_BITS-1:0]      ram_idx;
  logic [NUM_LANES-1:0]      ram_be;
  logic [NUM_LANES-1:0][7:0] ram_wdata;

  // Upper address bits are dropped so addresses alias modulo the depth.
  assign idx     = bus.addr[BASE_LSB+ADDR_BITS-1:BASE_LSB];
  assign bsel    = bus.addr[1:0];
  assign rd_word = mem[idx];
  assign req_ok  = (state_q == ST_READY) && !mis;
  assign wr_ok   = req_ok && bus.mWriteMem;

  // Alignment check: halves need addr[0]=0, words (and reserved size) addr[1:0]=0.
  always_comb begin
    mis = 1'b0;
    case (bus.mSize)
      2'b00:   mis = 1'b0;
      2'b01:   mis = bus.addr[0];
      default: mis = (bus.addr[1:0] != 2'b00);
    endcase
  end

  // Per-lane store enable and store byte; merged is the word as it reads
  // after this cycle's store, which gives write-first loads.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [1:0] LANE = 2'(l);
    assign lane_we[l] = wr_ok &&
                        ((bus.mSize == 2'b00) ? (bsel == LANE) :
                         (bus.mSize == 2'b01) ? (bsel[1] == LANE[1]) : 1'b1);
    assign wbyte[l]   = (bus.mSize == 2'b00) ? bus.dataIn[7:0] :
                        (bus.mSize == 2'b01) ? (LANE[0] ? bus.dataIn[15:8] : bus.dataIn[7:0]) :
                                               bus.dataIn[8*l +: 8];
    assign merged[l]  = lane_we[l] ? wbyte[l] : rd_word[l];
  end

  // Load extraction: shift selected lane(s) to bit 0, then sign/zero extend.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b       = merged[bsel];
    h       = {merged[{bsel[1], 1'b1}], merged[{bsel[1], 1'b0}]};
    ld_data = merged;
    case (bus.mSize)
      2'b00:   ld_data = {{24{bus.mSigned & b[7]}}, b};
      2'b01:   ld_data = {{16{bus.mSigned & h[15]}}, h};
      default: ld_data = merged;
    endcase
  end

  // Next-state for FSM, clear counter and registered outputs.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    data_out_d   = data_out_q;
    misaligned_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_BITS'(DEPTH - 1)) state_d = ST_READY;
      end
      default: begin
        misaligned_d = (bus.mWriteMem || bus.mReadMem) && mis;
        if (req_ok && bus.mReadMem) data_out_d = ld_data;
      end
    endcase
  end

  // RAM write port: sweep zeros during CLEAR, byte-lane stores in READY.
  always_comb begin
    ram_we    = 1'b0;
    ram_idx   = idx;
    ram_be    = '0;
    ram_wdata = wbyte;
    if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_idx   = clr_cnt_q;
      ram_be    = '1;
      ram_wdata = '0;
    end else if (wr_ok) begin
      ram_we = 1'b1;
      ram_be = lane_we;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q    <= '0;
      data_out_q   <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      data_out_q   <= data_out_d;
      misaligned_q <= misaligned_d;
    end
  end

  // RAM array; contents survive reset and are zeroed by the sweep instead.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (ram_be[l]) mem[ram_idx][l] <= ram_wdata[l];
      end
    end
  end

  assign bus.dataOut    = data_out_q;
  assign bus.misaligned = misaligned_q;
  assign bus.ready      = (state_q == ST_READY);
endmodule

// File: tb/tb_ppl_datamem_sized.sv
// Scoreboard bench for ppl_datamem_sized (ADDR_BITS=5, BASE_LSB=2).
module tb_ppl_datamem_sized;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [31:0] last_out = '0;

  typedef struct packed {
    logic [31:0] d;
    logic        m;
  } exp_t;
  exp_t sb[$];

  ppl_datamem_sized_if bus ();

  ppl_datamem_sized #(.ADDR_BITS(5), .BASE_LSB(2), .CLEAR_ON_RESET(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One request cycle: push expectation, drive, compare after the edge.
  task automatic req(input logic wr, input logic rd, input logic [31:0] a,
                     input logic [31:0] din, input logic [1:0] sz, input logic sg,
                     input logic [31:0] exp_d, input logic exp_m, input string tag);
    exp_t e;
    sb.push_back('{d: exp_d, m: exp_m});
    bus.addr = a; bus.dataIn = din; bus.mSize = sz; bus.mSigned = sg;
    bus.mWriteMem = wr; bus.mReadMem = rd;
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, "_data"}, bus.dataOut, e.d);
    chk({tag, "_mis"}, {31'b0, bus.misaligned}, {31'b0, e.m});
    last_out = e.d;
    bus.mWriteMem = 1'b0; bus.mReadMem = 1'b0;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] din, input logic [1:0] sz,
                    input logic exp_m, input string tag);
    req(1'b1, 1'b0, a, din, sz, 1'b0, last_out, exp_m, tag);
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                    input logic [31:0] exp_d, input string tag);
    req(1'b0, 1'b1, a, 32'h0, sz, sg, exp_d, 1'b0, tag);
  endtask

  // Count cycles until ready rises, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n;
    bus.addr = '0; bus.dataIn = '0; bus.mSize = 2'b10; bus.mSigned = 1'b0;
    bus.mWriteMem = 1'b0; bus.mReadMem = 1'b0;
    #1;
    chk("rst_ready", {31'b0, bus.ready}, 32'h0);
    chk("rst_dout", bus.dataOut, 32'h0);
    chk("rst_mis", {31'b0, bus.misaligned}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_ready(n);
    chk("sweep0_len", n, 32);

    // Preload nonzero data, then reset and re-sweep.
    for (int i = 0; i < 32; i++) st(32'(i * 4), 32'hA500_0000 | 32'(i + 1), 2'b10, 1'b0, "preload");
    ld(32'h14, 2'b10, 1'b0, 32'hA500_0006, "preload_rd");
    reset = 1'b1;
    #1;
    chk("rst2_dout", bus.dataOut, 32'h0);
    chk("rst2_ready", {31'b0, bus.ready}, 32'h0);
    last_out = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_ready(n);
    chk("sweep_len", n, 32);
    for (int i = 0; i < 32; i++) ld(32'(i * 4), 2'b10, 1'b0, 32'h0, "sweep_rd");

    // Word store/load.
    st(32'h10, 32'h1234_5678, 2'b10, 1'b0, "sw10");
    ld(32'h10, 2'b10, 1'b0, 32'h1234_5678, "lw10");

    // Sub-word merge and extension; upper dataIn bits must be ignored.
    st(32'h20, 32'hAABB_CCDD, 2'b10, 1'b0, "sw20");
    st(32'h21, 32'h1234_5680, 2'b00, 1'b0, "sb21");
    ld(32'h20, 2'b10, 1'b0, 32'hAABB_80DD, "lw20");
    ld(32'h21, 2'b00, 1'b1, 32'hFFFF_FF80, "lb21");
    ld(32'h21, 2'b00, 1'b0, 32'h0000_0080, "lbu21");
    ld(32'h22, 2'b01, 1'b1, 32'hFFFF_AABB, "lh22");
    ld(32'h22, 2'b01, 1'b0, 32'h0000_AABB, "lhu22");
    ld(32'h23, 2'b00, 1'b1, 32'hFFFF_FFAA, "lb23");
    ld(32'h20, 2'b00, 1'b0, 32'h0000_00DD, "lbu20");
    ld(32'h20, 2'b01, 1'b1, 32'hFFFF_80DD, "lh20");

    // Misalignment.
    st(32'h40, 32'h1111_1111, 2'b10, 1'b0, "sw40");
    st(32'h41, 32'h0000_BEEF, 2'b01, 1'b1, "sh41_bad");
    req(1'b0, 1'b1, 32'h42, 32'h0, 2'b10, 1'b0, last_out, 1'b1, "lw42_bad");
    req(1'b0, 1'b0, 32'h42, 32'h0, 2'b10, 1'b0, last_out, 1'b0, "idle");
    ld(32'h40, 2'b10, 1'b0, 32'h1111_1111, "lw40");
    req(1'b0, 1'b1, 32'h41, 32'h0, 2'b11, 1'b0, last_out, 1'b1, "lrsv41_bad");
    st(32'h42, 32'h5555_BEEF, 2'b01, 1'b0, "sh42");
    ld(32'h40, 2'b10, 1'b0, 32'hBEEF_1111, "lw40b");

    // Read-during-write and alias wrap.
    req(1'b1, 1'b1, 32'h0C, 32'hCAFE_F00D, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, "rdw0c");
    ld(32'h8C, 2'b10, 1'b0, 32'hCAFE_F00D, "lw8c_wrap");
    ld(32'h0C, 2'b11, 1'b0, 32'hCAFE_F00D, "lrsv0c");
    req(1'b1, 1'b1, 32'h0D, 32'h0000_0042, 2'b00, 1'b0, 32'h0000_0042, 1'b0, "rdw_sb0d");
    ld(32'h0C, 2'b10, 1'b0, 32'hCAFE_420D, "lw0c_merge");

    // Reset mid-sweep.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_dout", bus.dataOut, 32'h0);
    chk("midrst_ready", {31'b0, bus.ready}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    wait_ready(n);
    chk("midrst_sweep_len", n, 32);
    last_out = '0;
    ld(32'h10, 2'b10, 1'b0, 32'h0, "post_sweep_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
